// File: rtl/mux_sel_pipe_if.sv
// Handshake and data bundle between an upstream producer, the selector and its consumer.
interface mux_sel_pipe_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NPORTS = 3,
  parameter int unsigned SELW   = 2
);
  logic [NPORTS*WIDTH-1:0] in_data;
  logic [SELW-1:0]         in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_bad;
  logic [7:0]              bad_cnt;

  // Environment side: offers input words and accepts output words.
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_bad, bad_cnt
  );

  // Selector side.
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_bad, bad_cnt
  );
endinterface

// File: rtl/mux_sel_pipe.sv
// Port selector feeding a 2-entry skid buffer; out-of-range selects are flagged and counted.
module mux_sel_pipe #(
  parameter int unsigned       WIDTH       = 32,
  parameter int unsigned       NPORTS      = 3,
  parameter int unsigned       SELW        = 2,
  parameter int unsigned       BAD_HOLD    = 1,
  parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0
) (
  input logic           clk,
  input logic           rst,
  mux_sel_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t             state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             main_bad_q, main_bad_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             skid_bad_q, skid_bad_d;
  logic [WIDTH-1:0] last_good_q, last_good_d;
  logic [7:0]       bad_cnt_q, bad_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             sel_ok;
  logic [WIDTH-1:0] pick;
  logic [WIDTH-1:0] in_word;
  logic             in_xfer;
  logic             out_xfer;

  // Pick the addressed port, or the fallback word when the select is out of range.
  always_comb begin
    sel_ok = (32'(bus.in_sel) < NPORTS);
    pick   = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      if (32'(bus.in_sel) == k) pick = bus.in_data[k*WIDTH +: WIDTH];
    end
    if (sel_ok)             in_word = pick;
    else if (BAD_HOLD != 0) in_word = last_good_q;
    else                    in_word = DEFAULT_VAL;
  end

  // Occupancy next-state, buffer moves, last-good tracking and bad counter.
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    main_bad_d  = main_bad_q;
    skid_d      = skid_q;
    skid_bad_d  = skid_bad_q;
    last_good_d = last_good_q;
    bad_cnt_d   = bad_cnt_q;
    in_xfer     = bus.in_valid && in_ready_q;
    out_xfer    = out_valid_q && bus.out_ready;

    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d    = ONE;
          main_d     = in_word;
          main_bad_d = !sel_ok;
        end
      end
      ONE: begin
        if (in_xfer && !out_xfer) begin
          state_d    = FULL;
          skid_d     = in_word;
          skid_bad_d = !sel_ok;
        end else if (out_xfer && !in_xfer) begin
          state_d = EMPTY;
        end else if (in_xfer && out_xfer) begin
          main_d     = in_word;
          main_bad_d = !sel_ok;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move
        if (out_xfer) begin
          state_d    = ONE;
          main_d     = skid_q;
          main_bad_d = skid_bad_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (in_xfer && sel_ok) last_good_d = pick;
    if (in_xfer && !sel_ok && (bad_cnt_q != 8'hFF)) bad_cnt_d = bad_cnt_q + 8'd1;

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // State and datapath registers; reset clears both buffered words immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      main_bad_q  <= 1'b0;
      skid_q      <= '0;
      skid_bad_q  <= 1'b0;
      last_good_q <= DEFAULT_VAL;
      bad_cnt_q   <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      main_bad_q  <= main_bad_d;
      skid_q      <= skid_d;
      skid_bad_q  <= skid_bad_d;
      last_good_q <= last_good_d;
      bad_cnt_q   <= bad_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.out_bad   = main_bad_q;
  assign bus.bad_cnt   = bad_cnt_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed bench for mux_sel_pipe: a hold-policy instance and a default-value instance.
module tb_mux_sel_pipe;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [31:0] word_of [3] = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C};

  mux_sel_pipe_if #(.WIDTH(32), .NPORTS(3), .SELW(2)) bus_h ();
  mux_sel_pipe_if #(.WIDTH(32), .NPORTS(3), .SELW(2)) bus_d ();

  mux_sel_pipe #(
    .WIDTH(32), .NPORTS(3), .SELW(2), .BAD_HOLD(1), .DEFAULT_VAL(32'h0)
  ) dut_h (
    .clk(clk), .rst(rst), .bus(bus_h.slave)
  );

  mux_sel_pipe #(
    .WIDTH(32), .NPORTS(3), .SELW(2), .BAD_HOLD(0), .DEFAULT_VAL(32'h0000_DEAD)
  ) dut_d (
    .clk(clk), .rst(rst), .bus(bus_d.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_h.in_data = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
    bus_h.in_sel = 2'd0; bus_h.in_valid = 1'b0; bus_h.out_ready = 1'b1;
    bus_d.in_data = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
    bus_d.in_sel = 2'd0; bus_d.in_valid = 1'b0; bus_d.out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    total++; if (bus_h.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus_h.out_valid); end
    total++; if (bus_h.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus_h.in_ready); end
    total++; if (bus_h.out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", bus_h.out_data); end
    total++; if (bus_h.out_bad !== 1'b0) begin bad++; $display("FAIL reset_out_bad got=%b want=0", bus_h.out_bad); end
    total++; if (bus_h.bad_cnt !== 8'd0) begin bad++; $display("FAIL reset_bad_cnt got=%0d want=0", bus_h.bad_cnt); end
    total++; if (bus_d.out_data !== 32'h0) begin bad++; $display("FAIL reset_d_out_data got=%h want=0", bus_d.out_data); end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_select();
    bus_h.out_ready = 1'b1;
    bus_h.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_h.in_sel = 2'(i);
      step();
      total++; if (bus_h.out_valid !== 1'b1 || bus_h.out_data !== word_of[i] || bus_h.out_bad !== 1'b0) begin
        bad++; $display("FAIL select_%0d got v=%b d=%h b=%b want v=1 d=%h b=0", i, bus_h.out_valid, bus_h.out_data, bus_h.out_bad, word_of[i]);
      end
    end
    bus_h.in_valid = 1'b0;
    step();
    total++; if (bus_h.out_valid !== 1'b0) begin bad++; $display("FAIL select_drain got=%b want=0", bus_h.out_valid); end
  endtask

  task automatic test_bad_hold();
    bus_h.in_valid = 1'b1;
    bus_h.in_sel = 2'd1;
    step();
    total++; if (bus_h.out_data !== 32'hB || bus_h.out_bad !== 1'b0) begin
      bad++; $display("FAIL hold_first got d=%h b=%b want d=b b=0", bus_h.out_data, bus_h.out_bad);
    end
    bus_h.in_sel = 2'd3;
    step();
    total++; if (bus_h.out_data !== 32'hB || bus_h.out_bad !== 1'b1 || bus_h.bad_cnt !== 8'd1) begin
      bad++; $display("FAIL hold_bad got d=%h b=%b cnt=%0d want d=b b=1 cnt=1", bus_h.out_data, bus_h.out_bad, bus_h.bad_cnt);
    end
    bus_h.in_valid = 1'b0;
    step();
  endtask

  task automatic test_bad_default();
    bus_d.in_valid = 1'b1;
    bus_d.in_sel = 2'd1;
    step();
    total++; if (bus_d.out_data !== 32'hB || bus_d.out_bad !== 1'b0) begin
      bad++; $display("FAIL default_first got d=%h b=%b want d=b b=0", bus_d.out_data, bus_d.out_bad);
    end
    bus_d.in_sel = 2'd3;
    step();
    total++; if (bus_d.out_data !== 32'h0000_DEAD || bus_d.out_bad !== 1'b1 || bus_d.bad_cnt !== 8'd1) begin
      bad++; $display("FAIL default_bad got d=%h b=%b cnt=%0d want d=dead b=1 cnt=1", bus_d.out_data, bus_d.out_bad, bus_d.bad_cnt);
    end
    bus_d.in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    bus_h.out_ready = 1'b0;
    bus_h.in_valid = 1'b1;
    bus_h.in_sel = 2'd0;
    step();
    total++; if (bus_h.in_ready !== 1'b1 || bus_h.out_data !== 32'hA) begin
      bad++; $display("FAIL bp_w0 got rdy=%b d=%h want rdy=1 d=a", bus_h.in_ready, bus_h.out_data);
    end
    bus_h.in_sel = 2'd1;
    step();
    total++; if (bus_h.in_ready !== 1'b0 || bus_h.out_data !== 32'hA || bus_h.out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_full got rdy=%b v=%b d=%h want rdy=0 v=1 d=a", bus_h.in_ready, bus_h.out_valid, bus_h.out_data);
    end
    bus_h.in_sel = 2'd2;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (bus_h.in_ready !== 1'b0 || bus_h.out_data !== 32'hA || bus_h.out_valid !== 1'b1 || bus_h.out_bad !== 1'b0) begin
        bad++; $display("FAIL bp_stall_%0d got rdy=%b v=%b d=%h b=%b want rdy=0 v=1 d=a b=0", i, bus_h.in_ready, bus_h.out_valid, bus_h.out_data, bus_h.out_bad);
      end
    end
    bus_h.out_ready = 1'b1;
    step();
    total++; if (bus_h.out_data !== 32'hB || bus_h.in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_w1 got d=%h rdy=%b want d=b rdy=1", bus_h.out_data, bus_h.in_ready);
    end
    step();
    total++; if (bus_h.out_data !== 32'hC || bus_h.out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_w2 got v=%b d=%h want v=1 d=c", bus_h.out_valid, bus_h.out_data);
    end
    bus_h.in_valid = 1'b0;
    step();
    total++; if (bus_h.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", bus_h.out_valid); end
  endtask

  task automatic test_throughput();
    int seen;
    seen = 0;
    bus_h.out_ready = 1'b1;
    bus_h.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus_h.in_sel = 2'(i % 3);
      step();
      if (bus_h.out_valid === 1'b1) seen++;
      total++; if (bus_h.out_valid !== 1'b1 || bus_h.in_ready !== 1'b1 || bus_h.out_data !== word_of[i % 3]) begin
        bad++; $display("FAIL thru_%0d got v=%b rdy=%b d=%h want v=1 rdy=1 d=%h", i, bus_h.out_valid, bus_h.in_ready, bus_h.out_data, word_of[i % 3]);
      end
    end
    bus_h.in_valid = 1'b0;
    step();
    total++; if (seen != 20 || bus_h.out_valid !== 1'b0) begin
      bad++; $display("FAIL thru_count got=%0d v=%b want=20 v=0", seen, bus_h.out_valid);
    end
  endtask

  task automatic test_saturation();
    bus_h.out_ready = 1'b1;
    bus_h.in_valid = 1'b1;
    bus_h.in_sel = 2'd3;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 100) begin
        total++; if (bus_h.bad_cnt !== 8'd101) begin bad++; $display("FAIL sat_mid got=%0d want=101", bus_h.bad_cnt); end
      end
    end
    total++; if (bus_h.bad_cnt !== 8'd255) begin bad++; $display("FAIL sat_end got=%0d want=255", bus_h.bad_cnt); end
    total++; if (bus_h.out_data !== 32'hB || bus_h.out_bad !== 1'b1) begin
      bad++; $display("FAIL sat_hold got d=%h b=%b want d=b b=1", bus_h.out_data, bus_h.out_bad);
    end
    bus_h.in_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    bus_h.out_ready = 1'b0;
    bus_h.in_valid = 1'b1;
    bus_h.in_sel = 2'd0;
    step();
    bus_h.in_sel = 2'd1;
    step();
    total++; if (bus_h.in_ready !== 1'b0) begin bad++; $display("FAIL ar_full got rdy=%b want=0", bus_h.in_ready); end
    bus_h.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (bus_h.out_valid !== 1'b0 || bus_h.in_ready !== 1'b1 || bus_h.bad_cnt !== 8'd0 || bus_h.out_data !== 32'h0) begin
      bad++; $display("FAIL ar_immediate got v=%b rdy=%b cnt=%0d d=%h want v=0 rdy=1 cnt=0 d=0", bus_h.out_valid, bus_h.in_ready, bus_h.bad_cnt, bus_h.out_data);
    end
    step();
    rst = 1'b0;
    bus_h.out_ready = 1'b1;
    bus_h.in_valid = 1'b1;
    bus_h.in_sel = 2'd3;
    step();
    total++; if (bus_h.out_valid !== 1'b1 || bus_h.out_data !== 32'h0 || bus_h.out_bad !== 1'b1 || bus_h.bad_cnt !== 8'd1) begin
      bad++; $display("FAIL ar_first got v=%b d=%h b=%b cnt=%0d want v=1 d=0 b=1 cnt=1", bus_h.out_valid, bus_h.out_data, bus_h.out_bad, bus_h.bad_cnt);
    end
    bus_h.in_sel = 2'd2;
    step();
    total++; if (bus_h.out_valid !== 1'b1 || bus_h.out_data !== 32'hC || bus_h.out_bad !== 1'b0) begin
      bad++; $display("FAIL ar_second got v=%b d=%h b=%b want v=1 d=c b=0", bus_h.out_valid, bus_h.out_data, bus_h.out_bad);
    end
    bus_h.in_valid = 1'b0;
    step();
    total++; if (bus_h.out_valid !== 1'b0) begin bad++; $display("FAIL ar_drain got=%b want=0", bus_h.out_valid); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_select();
    test_bad_hold();
    test_bad_default();
    test_backpressure();
    test_throughput();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_sel_pipe.md
MUX_SEL_PIPE -- requirements
Module: mux_sel_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data width of each input port and of the output.
REQ-002 Parameter NPORTS, default 3, legal range 2..16: number of selectable input ports.
REQ-003 Parameter SELW, default 2: width of the select field; SHALL be at least ceil(log2(NPORTS)).
REQ-004 Parameter BAD_HOLD, default 1: policy for out-of-range select; 1 = repeat the last valid data, 0 = output DEFAULT_VAL.
REQ-005 Parameter DEFAULT_VAL, default 0 (WIDTH bits): value used for out-of-range select when BAD_HOLD=0.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 in_data  input  NPORTS*WIDTH  packed ports; port k occupies bits [k*WIDTH +: WIDTH].
REQ-009 in_sel  input  SELW  port index, sampled with in_data.
REQ-010 in_valid  input  1  upstream offers in_data/in_sel this cycle.
REQ-011 in_ready  output  1  block can accept this cycle.
REQ-012 out_data  output  WIDTH  selected word.
REQ-013 out_valid  output  1  out_data is valid.
REQ-014 out_ready  input  1  downstream accepts out_data this cycle.
REQ-015 out_bad  output  1  the word at the output came from an out-of-range select.
REQ-016 bad_cnt  output  8  saturating count of accepted out-of-range selects.

Function
REQ-017 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; an output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-018 The datapath SHALL be a 2-entry skid buffer: a main register driving the outputs and a skid register.
REQ-019 Latency SHALL be 1 cycle: a word accepted at edge N with the buffer empty SHALL appear on out_data after edge N.
REQ-020 in_ready SHALL be a registered signal equal to "skid register empty"; it SHALL NOT depend combinationally on out_ready.
REQ-021 Occupancy states: EMPTY (0 words), ONE (main only), FULL (main + skid).
- EMPTY: input transfer -> ONE.
- ONE: input transfer with no output transfer -> FULL; output transfer with no input transfer -> EMPTY; both -> ONE.
- FULL: output transfer -> ONE and the skid word moves to main on the same edge; no input is accepted in FULL.
REQ-022 With out_ready held at 1 and in_valid held at 1, the block SHALL accept and emit one word per cycle with no bubbles.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_bad and out_valid SHALL hold stable.
REQ-024 Selection SHALL take place at acceptance: the stored word = port in_sel when in_sel < NPORTS.
REQ-025 in_sel >= NPORTS: the stored word SHALL be last_good when BAD_HOLD=1 and DEFAULT_VAL when BAD_HOLD=0; the stored bad flag SHALL be 1.
REQ-026 last_good SHALL update only on acceptance of an in-range select and SHALL reset to DEFAULT_VAL.
REQ-027 bad_cnt SHALL increment by 1 on each accepted out-of-range select and saturate at 255.
REQ-028 Words SHALL leave in acceptance order; no word is dropped or duplicated.

Reset
REQ-029 While rst=1: out_valid=0, in_ready=1, out_data=0, out_bad=0, bad_cnt=0, last_good=DEFAULT_VAL, occupancy EMPTY; this takes effect immediately, without a clock edge.
REQ-030 Reset asserted mid-operation SHALL discard both buffered words; the first accepted word after release SHALL appear after exactly 1 edge.

Verification
REQ-031 NPORTS=3, ports 0xA/0xB/0xC, out_ready=1, in_sel 0,1,2 on consecutive cycles -> out_data 0xA,0xB,0xC on the three following cycles, out_bad=0.
REQ-032 BAD_HOLD=1: accept sel=1 (0xB), then sel=3 -> second output = 0xB with out_bad=1, bad_cnt=1; BAD_HOLD=0, DEFAULT_VAL=0xDEAD: sel=3 -> 0xDEAD, out_bad=1.
REQ-033 Backpressure: out_ready=0, offer words W0,W1,W2 -> W0,W1 accepted, in_ready=0 after the second accept, W2 held; raise out_ready -> W0,W1,W2 emitted in order, no loss.
REQ-034 Throughput: out_ready=1, in_valid=1 for 20 cycles -> 20 transfers, out_valid continuously 1 from cycle 2.
REQ-035 Saturation: 300 accepted out-of-range selects -> bad_cnt=255.
REQ-036 Assert rst asynchronously between edges while FULL -> out_valid=0 and in_ready=1 before the next edge; after release, one word -> output after 1 edge.
